tick_divider_multi: RTL and testbench

- Parametrised multi-channel clock-enable generator for the traffic-light controller.
- Produces NUM_CH independent single-cycle tick pulses from clk50M, each channel with its own runtime-programmable divide ratio loaded through a valid/ready port.
- Also provides a reset-synchronised rst_sync for downstream FSMs.
- Downstream logic stays on clk50M and qualifies on tick; no derived clocks.

---
 rtl/tick_pkg.sv | 21 ++
 rtl/tick_chan.sv | 112 +++++++++++
 rtl/tick_divider_multi.sv | 80 ++++++++
 tb/tb_tick_divider_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_pkg
//  Purpose  : Shared constants and types for the tick divider block.
//  Revision : 1.0 - initial release
// ============================================================================
package tick_pkg;

    // System clock and the standard divide ratios derived from it.
    localparam int unsigned CLK_HZ  = 50000000;
    localparam int unsigned DIV_1HZ = 50000000;
    localparam int unsigned DIV_2HZ = 25000000;

    // Default divide counter / ratio width.
    localparam int CNT_W_DEFAULT = 32;

    // Divide ratio at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage : tick_pkg
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
// ============================================================================
//  Module   : tick_chan
//  Purpose  : One tick channel: free-running divide counter, active ratio,
//             shadow ratio with pending flag, registered tick pulse and
//             optional square-wave output (built only with TICK_SQ_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tick_chan
    import tick_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DIV_1HZ)
) (
    input  logic             clk50M,
    input  logic             Reset,
    input  logic             enable_i,
    input  logic             sync_clr_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pending_o
);

    // A zero reset ratio would never wrap; treat it as 1 like a runtime write.
    localparam logic [CNT_W-1:0] DIV_RST = (DIV_DEFAULT == '0) ? CNT_W'(1) : DIV_DEFAULT;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             wrap_w;
    logic             apply_w;
    logic [CNT_W-1:0] cfg_div_clamped_w;

    // Next-state logic: wrap detection, shadow apply and counter advance.
    always_comb begin
        wrap_w            = enable_i & (cnt_q == (div_q - CNT_W'(1)));
        apply_w           = pending_q & (sync_clr_i | wrap_w);
        cfg_div_clamped_w = (cfg_div_i == '0) ? CNT_W'(1) : cfg_div_i;

        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pending_d = pending_q;
        // sync_clr realigns the channel and suppresses a coincident wrap tick.
        tick_d   = wrap_w & ~sync_clr_i;

        if (sync_clr_i || wrap_w) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The running period always finishes at the old ratio; the new one
        // takes over exactly at the period boundary.
        if (apply_w) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
        end

        // An accept only happens with pending clear, so it never races an
        // apply; an accept on a wrap cycle waits for the following wrap.
        if (cfg_we_i) begin
            shadow_d  = cfg_div_clamped_w;
            pending_d = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

`ifdef TICK_SQ_EN
    logic sq_q;

    // Square wave toggles together with each tick; sync_clr realigns it low.
    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset) begin
            sq_q <= 1'b0;
        end else if (sync_clr_i) begin
            sq_q <= 1'b0;
        end else if (wrap_w) begin
            sq_q <= ~sq_q;
        end
    end

    assign sq_o = sq_q;
`else
    assign sq_o = 1'b0;
`endif

    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tick_divider_multi
//  Purpose  : Multi-channel clock-enable generator. NUM_CH independent tick
//             channels with runtime-programmable ratios loaded through a
//             valid/ready port, plus a release-synchronised reset output.
//             Define TICK_SQ_EN to build the per-channel square-wave flops.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_divider_multi
    import tick_pkg::*;
#(
    parameter int               NUM_CH          = 2,
    parameter int               CH_W            = 1,
    parameter int               CNT_W           = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_DEFAULT     = CNT_W'(DIV_1HZ),
    parameter int               RST_SYNC_STAGES = 2
) (
    input  logic              clk50M,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic              rst_sync
);

    localparam int NUM_SEL = 2 ** CH_W;

    logic [RST_SYNC_STAGES-1:0] rst_chain_q;
    logic [NUM_CH-1:0]          pending_w;
    logic [NUM_SEL-1:0]         pending_sel_w;
    logic [NUM_CH-1:0]          cfg_we_w;

    // Reset release chain: asserts with Reset, releases after the last stage.
    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset) begin
            rst_chain_q <= '1;
        end else begin
            rst_chain_q <= {rst_chain_q[RST_SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = rst_chain_q[RST_SYNC_STAGES-1];

    // Ready mux over registered pending bits; an unpopulated channel select
    // reads as ready so a stray request is consumed instead of stalling.
    always_comb begin
        pending_sel_w                = '0;
        pending_sel_w[NUM_CH-1:0]    = pending_w;
        cfg_ready                    = ~pending_sel_w[cfg_ch];
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign cfg_we_w[gi] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(gi));

            tick_chan #(
                .CNT_W       (CNT_W),
                .DIV_DEFAULT (DIV_DEFAULT)
            ) u_chan (
                .clk50M     (clk50M),
                .Reset      (Reset),
                .enable_i   (enable[gi]),
                .sync_clr_i (sync_clr),
                .cfg_we_i   (cfg_we_w[gi]),
                .cfg_div_i  (cfg_div),
                .tick_o     (tick[gi]),
                .sq_o       (sq[gi]),
                .pending_o  (pending_w[gi])
            );
        end
    endgenerate

endmodule : tick_divider_multi
`default_nettype wire

// File: tb/tb_tick_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_divider_multi
//  Purpose  : Self-checking bench for tick_divider_multi against a
//             behavioural per-channel period model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_divider_multi;

    localparam int NUM_CH  = 2;
    localparam int CH_W    = 1;
    localparam int CNT_W   = 32;
    localparam int DIV_DEF = 4;
    localparam int STAGES  = 2;
`ifdef TICK_SQ_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic              clk50M = 1'b0;
    logic              Reset;
    logic [NUM_CH-1:0] enable;
    logic              sync_clr;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              rst_sync;

    always #10 clk50M = ~clk50M;

    tick_divider_multi #(
        .NUM_CH          (NUM_CH),
        .CH_W            (CH_W),
        .CNT_W           (CNT_W),
        .DIV_DEFAULT     (CNT_W'(DIV_DEF)),
        .RST_SYNC_STAGES (STAGES)
    ) dut (
        .clk50M    (clk50M),
        .Reset     (Reset),
        .enable    (enable),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .sq        (sq),
        .rst_sync  (rst_sync)
    );

    // Reference model: position within the current period, active and
    // queued ratio, and the expected registered outputs.
    int m_pos  [NUM_CH];
    int m_div  [NUM_CH];
    int m_shad [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_sq   [NUM_CH];
    int m_rs_edges;
    bit m_acc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pos[i] = 0; m_div[i] = DIV_DEF; m_shad[i] = 0;
            m_pend[i] = 1'b0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
        end
        m_rs_edges = 0;
    endfunction

    // One rising edge of the reference: a channel emits a tick when its
    // enabled cycle completes the period; queued ratios take effect at a
    // period boundary or a realignment.
    function automatic void model_edge();
        m_acc = cfg_valid && !m_pend[cfg_ch];
        if (Reset) begin
            model_reset();
            m_acc = 1'b0;
            return;
        end
        if (m_rs_edges < STAGES) m_rs_edges++;
        for (int i = 0; i < NUM_CH; i++) begin
            bit boundary;
            boundary = 1'b0;
            m_tick[i] = 1'b0;
            if (sync_clr) begin
                m_pos[i] = 0; m_sq[i] = 1'b0; boundary = 1'b1;
            end else if (enable[i]) begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] >= m_div[i]) begin
                    m_pos[i] = 0; m_tick[i] = 1'b1; boundary = 1'b1;
                    if (SQ_EN) m_sq[i] = !m_sq[i];
                end
            end
            if (boundary && m_pend[i]) begin
                m_div[i] = m_shad[i]; m_pend[i] = 1'b0;
            end
            if (m_acc && (int'(cfg_ch) == i)) begin
                m_shad[i] = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_pend[i] = 1'b1;
            end
        end
    endfunction

    task automatic compare();
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tick[i]));
            chk($sformatf("sq[%0d]", i), 32'(sq[i]), 32'(m_sq[i]));
        end
        chk("rst_sync", 32'(rst_sync), 32'(m_rs_edges < STAGES));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
    endtask

    task automatic step();
        @(posedge clk50M);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_req(input int ch, input int div);
        bit done;
        done = 1'b0;
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(div);
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            done = m_acc;
        end
        cfg_valid = 1'b0;
        if (!done) chk("cfg_accept_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int ch, input int pos);
        bit done;
        done = (m_pos[ch] == pos);
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            done = (m_pos[ch] == pos);
        end
        if (!done) chk("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_applied(input int ch);
        bit done;
        done = !m_pend[ch];
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            done = !m_pend[ch];
        end
        if (!done) chk("apply_timeout", 0, 1);
    endtask

    initial begin
        Reset = 1'b1; enable = '0; sync_clr = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();
        #1;
        chk("reset_tick", 32'(tick), 0);
        chk("reset_sq", 32'(sq), 0);
        chk("reset_rst_sync", 32'(rst_sync), 1);
        run(3);

        // Default ratio 4 on both channels: ticks at cycles 4, 8, 12.
        enable = 2'b11;
        Reset  = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("tick_default_period", 32'(tick), (c % 4 == 0) ? 32'h3 : 32'h0);
            chk("rst_sync_release", 32'(rst_sync), 32'(c < STAGES));
        end

        // Ch0 to ratio 5, then a ratio 3 request landing mid-period.
        cfg_req(0, 5);
        wait_applied(0);
        wait_pos(0, 2);
        cfg_req(0, 3);
        run(20);

        // Ratio 0 on ch1 is stored as 1: tick every enabled cycle.
        cfg_req(1, 0);
        wait_applied(1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("div1_every_cycle", 32'(tick[1]), 1);
        end

        // Enable drop on ch0 at position 2 with ratio 4.
        cfg_req(0, 4);
        wait_applied(0);
        wait_pos(0, 2);
        enable[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("disabled_no_tick", 32'(tick[0]), 0);
        end
        enable[0] = 1'b1;
        step();
        chk("reenable_first", 32'(tick[0]), 0);
        step();
        chk("reenable_tick", 32'(tick[0]), 1);

        // sync_clr at ch0's last count with a shadow parked on disabled ch1.
        enable[1] = 1'b0;
        cfg_req(1, 3);
        run(3);
        chk("parked_pending", 32'(cfg_ready), 0);
        wait_pos(0, 3);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("sync_clr_no_tick", 32'(tick), 0);
        enable = 2'b11;
        run(13);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!(cfg_valid && !m_acc)) begin
                cfg_valid = ($urandom % 4) == 0;
                cfg_ch    = CH_W'($urandom % NUM_CH);
                cfg_div   = CNT_W'($urandom_range(0, 6));
            end
            for (int i = 0; i < NUM_CH; i++) enable[i] = ($urandom % 8) != 0;
            sync_clr = ($urandom % 40) == 0;
        end
        cfg_valid = 1'b0; sync_clr = 1'b0; enable = 2'b11;
        run(5);

        // Reset mid-period with a parked shadow.
        enable[1] = 1'b0;
        cfg_req(1, 6);
        run(2);
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        cfg_ch = 1'b1;
        #1;
        chk("async_reset_tick", 32'(tick), 0);
        chk("async_reset_sq", 32'(sq), 0);
        chk("async_reset_rst_sync", 32'(rst_sync), 1);
        chk("async_reset_ready", 32'(cfg_ready), 1);
        run(2);
        Reset = 1'b0;
        enable = 2'b11;
        run(24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tick_divider_multi
`default_nettype wire
